// File: rtl/count_enable_ctrl_pkg.sv
// count_enable_ctrl_pkg
//   Board constants, default prescaler/debounce settings and the run/stop
//   state encoding shared by the count enable control stage.
//   No ports.
package count_enable_ctrl_pkg;

    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned DEFAULT_DIV       = 50_000_000;  // 1 Hz at CLK_HZ
    localparam int unsigned DEFAULT_DIV_W     = 26;
    localparam int unsigned DEFAULT_DB_CYCLES = 1_000_000;   // 20 ms at CLK_HZ
    localparam int unsigned DEFAULT_DB_W      = 20;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_ZEROING = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/count_enable_ctrl_if.sv
// count_enable_ctrl_if
//   Groups the pushbutton inputs and counter control outputs of
//   count_enable_ctrl.
//   key_run, key_zero     : raw pushbuttons, active-high, asynchronous, bouncy
//   enable                : one-cycle counter enable pulse per prescaler wrap
//   count_clear           : one-cycle counter zero request
//   running               : high while the controller is in RUNNING
//   master modport drives the keys (board / bench); slave is the controller.
interface count_enable_ctrl_if;

    logic key_run;
    logic key_zero;
    logic enable;
    logic count_clear;
    logic running;

    modport master (
        output key_run,
        output key_zero,
        input  enable,
        input  count_clear,
        input  running
    );

    modport slave (
        input  key_run,
        input  key_zero,
        output enable,
        output count_clear,
        output running
    );

endinterface

// File: rtl/count_enable_ctrl_key_debounce.sv
// key_debounce
//   Two-flop synchroniser, debouncer and rising-edge press detector for one
//   raw pushbutton.
//   clock   : system clock, rising edge
//   clear   : synchronous active-high reset
//   key_raw : raw asynchronous key level
//   press   : one-cycle pulse when the accepted level changes 0 -> 1
module key_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned DB_W      = 20
) (
    input  logic clock,
    input  logic clear,
    input  logic key_raw,
    output logic press
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    // The counter measures how long the synced key has disagreed with the
    // accepted level without interruption; any agreement restarts it, so a
    // new level is only taken after DB_CYCLES consecutive cycles of it.
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/count_enable_ctrl.sv
// count_enable_ctrl
//   Upstream control for the 16-bit counter: debounces the run/stop and
//   zero pushbuttons, runs the STOPPED/RUNNING/ZEROING state machine and the
//   prescaler that paces the counter enable.
//   clock : system clock, rising edge
//   clear : synchronous active-high reset
//   bus   : slave side of count_enable_ctrl_if (keys in; enable,
//           count_clear, running out)
module count_enable_ctrl
    import count_enable_ctrl_pkg::*;
#(
    parameter int unsigned DIV       = DEFAULT_DIV,
    parameter int unsigned DIV_W     = DEFAULT_DIV_W,
    parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int unsigned DB_W      = DEFAULT_DB_W
) (
    input  logic                 clock,
    input  logic                 clear,
    count_enable_ctrl_if.slave   bus
);

    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);

    logic run_press;
    logic zero_press;

    ctrl_state_e      state_q, state_d;
    logic [DIV_W-1:0] pre_q, pre_d;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_run_key (
        .clock   (clock),
        .clear   (clear),
        .key_raw (bus.key_run),
        .press   (run_press)
    );

    key_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_zero_key (
        .clock   (clock),
        .clear   (clear),
        .key_raw (bus.key_zero),
        .press   (zero_press)
    );

    // Zero is tested before run in every state so it wins a tie. The
    // prescaler holds while stopped so a pause keeps the pulse phase.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        unique case (state_q)
            ST_STOPPED: begin
                if (zero_press) begin
                    state_d = ST_ZEROING;
                end else if (run_press) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + DIV_W'(1);
                if (zero_press) begin
                    state_d = ST_ZEROING;
                end else if (run_press) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_ZEROING: begin
                state_d = ST_STOPPED;
                pre_d   = '0;
            end
            default: begin
                state_d = ST_STOPPED;
                pre_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_STOPPED;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.enable      = (state_q == ST_RUNNING) && (pre_q == PRE_LAST);
    assign bus.count_clear = (state_q == ST_ZEROING);
    assign bus.running     = (state_q == ST_RUNNING);

endmodule
